// File: rtl/exe_stage_module.sv
// Execute stage: operand forwarding, val2 generation, ALU with NZCV flags,
// branch target, and the EXE/MEM pipeline register with freeze.
module exe_stage_module #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             wb_en_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             s_in,
  input  logic             imm_in,
  input  logic [3:0]       exe_cmd_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] val_Rn_in,
  input  logic [WIDTH-1:0] val_Rm_in,
  input  logic [11:0]      shift_operand_in,
  input  logic [23:0]      signed_imm_24_in,
  input  logic [3:0]       dest_in,
  input  logic [1:0]       sel_src1,
  input  logic [1:0]       sel_src2,
  input  logic [WIDTH-1:0] fwd_mem_val,
  input  logic [WIDTH-1:0] fwd_wb_val,
  output logic             wb_en_out,
  output logic             mem_r_en_out,
  output logic             mem_w_en_out,
  output logic [WIDTH-1:0] alu_res_out,
  output logic [WIDTH-1:0] val_Rm_out,
  output logic [3:0]       dest_out,
  output logic [WIDTH-1:0] branch_address,
  output logic [3:0]       status_out,
  output logic             wb_en_hazard_in,
  output logic [3:0]       dest_hazard_in
);

  localparam int unsigned SW = WIDTH + 1;

  logic [WIDTH-1:0] w_rn;
  logic [WIDTH-1:0] w_rm;
  logic [WIDTH-1:0] w_val2;
  logic [4:0]       w_shamt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_valid;
  logic             w_cin;
  logic [3:0]       w_nzcv;

  logic             r_wb_en;
  logic             r_mem_r_en;
  logic             r_mem_w_en;
  logic [WIDTH-1:0] r_alu_res;
  logic [WIDTH-1:0] r_val_rm;
  logic [3:0]       r_dest;
  logic [3:0]       r_status;

  // Rotate right; a zero amount yields v because the left shift by WIDTH clears.
  function automatic logic [WIDTH-1:0] f_ror(input logic [WIDTH-1:0] v,
                                             input logic [4:0]       s);
    f_ror = (v >> s) | (v << (6'(WIDTH) - {1'b0, s}));
  endfunction

  always_comb begin
    case (sel_src1)
      2'b01:   w_rn = fwd_mem_val;
      2'b10:   w_rn = fwd_wb_val;
      default: w_rn = val_Rn_in;
    endcase
  end

  always_comb begin
    case (sel_src2)
      2'b01:   w_rm = fwd_mem_val;
      2'b10:   w_rm = fwd_wb_val;
      default: w_rm = val_Rm_in;
    endcase
  end

  assign w_shamt = shift_operand_in[11:7];
  assign w_cin   = r_status[1];

  // Second operand: memory offset, rotated immediate, or shifted register.
  always_comb begin
    w_val2 = w_rm;
    if (mem_r_en_in || mem_w_en_in) begin
      w_val2 = WIDTH'(shift_operand_in);
    end else if (imm_in) begin
      w_val2 = f_ror(WIDTH'(shift_operand_in[7:0]), {shift_operand_in[11:8], 1'b0});
    end else if (w_shamt != 5'd0) begin
      case (shift_operand_in[6:5])
        2'b00:   w_val2 = w_rm << w_shamt;
        2'b01:   w_val2 = w_rm >> w_shamt;
        2'b10:   w_val2 = WIDTH'($signed(w_rm) >>> w_shamt);
        default: w_val2 = f_ror(w_rm, w_shamt);
      endcase
    end
  end

  // Subtract is done as Rn + ~val2 + 1 so the carry out is the NOT-borrow.
  always_comb begin
    w_sum   = '0;
    w_res   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_valid = 1'b1;
    case (exe_cmd_in)
      4'b0001: w_res = w_val2;
      4'b1001: w_res = ~w_val2;
      4'b0010, 4'b0011: begin
        w_sum = {1'b0, w_rn} + {1'b0, w_val2} + SW'(w_cin & exe_cmd_in[0]);
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (w_rn[WIDTH-1] == w_val2[WIDTH-1]) && (w_res[WIDTH-1] != w_rn[WIDTH-1]);
      end
      4'b0100, 4'b0101: begin
        w_sum = {1'b0, w_rn} + {1'b0, ~w_val2} + SW'(exe_cmd_in[0] ? w_cin : 1'b1);
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (w_rn[WIDTH-1] != w_val2[WIDTH-1]) && (w_res[WIDTH-1] != w_rn[WIDTH-1]);
      end
      4'b0110: w_res = w_rn & w_val2;
      4'b0111: w_res = w_rn | w_val2;
      4'b1000: w_res = w_rn ^ w_val2;
      default: w_valid = 1'b0;
    endcase
  end

  assign w_nzcv = {w_valid & w_res[WIDTH-1], w_valid & (w_res == '0), w_c, w_v};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
      r_mem_w_en <= 1'b0;
      r_alu_res  <= '0;
      r_val_rm   <= '0;
      r_dest     <= '0;
    end else if (!freeze) begin
      r_wb_en    <= wb_en_in;
      r_mem_r_en <= mem_r_en_in;
      r_mem_w_en <= mem_w_en_in;
      r_alu_res  <= w_res;
      r_val_rm   <= w_rm;
      r_dest     <= dest_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_status <= '0;
    end else if (!freeze && s_in) begin
      r_status <= w_nzcv;
    end
  end

  assign wb_en_out       = r_wb_en;
  assign mem_r_en_out    = r_mem_r_en;
  assign mem_w_en_out    = r_mem_w_en;
  assign alu_res_out     = r_alu_res;
  assign val_Rm_out      = r_val_rm;
  assign dest_out        = r_dest;
  assign status_out      = r_status;
  assign branch_address  = pc_in + {{(WIDTH-26){signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};
  assign wb_en_hazard_in = wb_en_in;
  assign dest_hazard_in  = dest_in;

endmodule

// File: tb/tb_exe_stage_module.sv
// Bench for exe_stage_module: arithmetic reference model checked every cycle
// plus directed vectors with hand-computed expectations.
module tb_exe_stage_module;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, s_in, imm_in;
  logic [3:0]  exe_cmd_in;
  logic [31:0] pc_in, val_Rn_in, val_Rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  dest_in;
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] fwd_mem_val, fwd_wb_val;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out;
  logic [31:0] alu_res_out, val_Rm_out, branch_address;
  logic [3:0]  dest_out, status_out;
  logic        wb_en_hazard_in;
  logic [3:0]  dest_hazard_in;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  logic        e_wb, e_mr, e_mw;
  logic [31:0] e_alu, e_rm;
  logic [3:0]  e_dest, e_status;

  exe_stage_module #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .s_in(s_in), .imm_in(imm_in), .exe_cmd_in(exe_cmd_in), .pc_in(pc_in),
    .val_Rn_in(val_Rn_in), .val_Rm_in(val_Rm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .sel_src1(sel_src1), .sel_src2(sel_src2),
    .fwd_mem_val(fwd_mem_val), .fwd_wb_val(fwd_wb_val),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .alu_res_out(alu_res_out), .val_Rm_out(val_Rm_out), .dest_out(dest_out),
    .branch_address(branch_address), .status_out(status_out),
    .wb_en_hazard_in(wb_en_hazard_in), .dest_hazard_in(dest_hazard_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
    longint unsigned x;
    x = {32'd0, v};
    x = (x | (x << 32)) >> n;
    return 32'(x);
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v);
    if (sel == 2'd1) return fwd_mem_val;
    if (sel == 2'd2) return fwd_wb_val;
    return reg_v;
  endfunction

  function automatic logic [31:0] model_val2(input logic [31:0] rm);
    int amt;
    amt = int'(shift_operand_in[11:7]);
    if (mem_r_en_in || mem_w_en_in) return {20'd0, shift_operand_in};
    if (imm_in) return rotr({24'd0, shift_operand_in[7:0]}, 2 * int'(shift_operand_in[11:8]));
    case (shift_operand_in[6:5])
      2'd0:    return 32'({32'd0, rm} << amt);
      2'd1:    return rm >> amt;
      2'd2:    return 32'(longint'($signed(rm)) >>> amt);
      default: return rotr(rm, amt);
    endcase
  endfunction

  // Reference ALU: wide unsigned sums for carry, wide signed sums for overflow.
  function automatic void model_alu(output logic [31:0] res, output logic [3:0] nzcv);
    logic [31:0] a, b;
    longint ua, ub, sa, sb, wide, sv;
    longint cin;
    bit c, v, known;
    a   = pick(sel_src1, val_Rn_in);
    b   = model_val2(pick(sel_src2, val_Rm_in));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    cin = longint'({63'd0, e_status[1]});
    c = 1'b0; v = 1'b0; known = 1'b1; sv = 0; res = '0;
    case (exe_cmd_in)
      4'd1: res = b;
      4'd9: res = ~b;
      4'd2: begin wide = ua + ub;       res = 32'(wide); c = (wide >= 64'h1_0000_0000); sv = sa + sb; end
      4'd3: begin wide = ua + ub + cin; res = 32'(wide); c = (wide >= 64'h1_0000_0000); sv = sa + sb + cin; end
      4'd4: begin res = 32'(ua - ub);             c = (ua >= ub);             sv = sa - sb; end
      4'd5: begin res = 32'(ua - ub - (1 - cin)); c = (ua >= ub + (1 - cin)); sv = sa - sb - (1 - cin); end
      4'd6: res = a & b;
      4'd7: res = a | b;
      4'd8: res = a ^ b;
      default: known = 1'b0;
    endcase
    if (exe_cmd_in inside {4'd2, 4'd3, 4'd4, 4'd5})
      v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    nzcv = {known && res[31], known && (res == 32'd0), c, v};
  endfunction

  function automatic logic [31:0] model_branch();
    longint off;
    off = longint'({40'd0, signed_imm_24_in});
    if (signed_imm_24_in[23]) off = off - 64'sd16777216;
    return 32'(longint'({32'd0, pc_in}) + off * 4);
  endfunction

  always @(posedge clk or negedge rst) begin
    logic [31:0] r;
    logic [3:0]  f;
    if (!rst) begin
      e_wb = 1'b0; e_mr = 1'b0; e_mw = 1'b0;
      e_alu = '0; e_rm = '0; e_dest = '0; e_status = '0;
    end else if (!freeze) begin
      model_alu(r, f);
      e_wb   = wb_en_in;
      e_mr   = mem_r_en_in;
      e_mw   = mem_w_en_in;
      e_alu  = r;
      e_rm   = pick(sel_src2, val_Rm_in);
      e_dest = dest_in;
      if (s_in) e_status = f;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_alu_res_out", alu_res_out, e_alu);
      chk("m_val_Rm_out", val_Rm_out, e_rm);
      chk("m_dest_out", 32'(dest_out), 32'(e_dest));
      chk("m_ctrl_out", 32'({wb_en_out, mem_r_en_out, mem_w_en_out}), 32'({e_wb, e_mr, e_mw}));
      chk("m_status_out", 32'(status_out), 32'(e_status));
      chk("m_branch_address", branch_address, model_branch());
      chk("m_hazard", 32'({wb_en_hazard_in, dest_hazard_in}), 32'({wb_en_in, dest_in}));
    end
  end

  task automatic drive(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                       input logic [11:0] so, input logic imm, input logic s,
                       input logic mr, input logic mw);
    exe_cmd_in = cmd; val_Rn_in = rn; val_Rm_in = rm; shift_operand_in = so;
    imm_in = imm; s_in = s; mem_r_en_in = mr; mem_w_en_in = mw;
    sel_src1 = 2'd0; sel_src2 = 2'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; freeze = 1'b0; wb_en_in = 1'b0; dest_in = '0;
    pc_in = '0; signed_imm_24_in = '0; fwd_mem_val = '0; fwd_wb_val = '0;
    drive(4'd0, 32'd0, 32'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    chk_en = 1'b1;
    chk("reset_status", 32'(status_out), 32'd0);
    chk("reset_alu", alu_res_out, 32'd0);

    wb_en_in = 1'b1; dest_in = 4'd3;
    drive(4'b0010, 32'h7FFF_FFFF, 32'd0, 12'h001, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk("add_res", alu_res_out, 32'h8000_0000);
    chk("add_nzcv", 32'(status_out), 32'h9);
    chk("add_dest", 32'(dest_out), 32'd3);

    drive(4'b0100, 32'd5, 32'd5, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("sub_res", alu_res_out, 32'd0);
    chk("sub_nzcv", 32'(status_out), 32'h6);

    drive(4'b0101, 32'd5, 32'd3, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("sbc_res", alu_res_out, 32'd2);
    chk("sbc_status_held", 32'(status_out), 32'h6);

    drive(4'b0001, 32'd0, 32'h8000_0000, 12'h0A0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("mov_lsr1", alu_res_out, 32'h4000_0000);
    drive(4'b0001, 32'd0, 32'h8000_0000, 12'h0C0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("mov_asr1", alu_res_out, 32'hC000_0000);
    drive(4'b0001, 32'd0, 32'h0000_00F1, 12'h270, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("mov_ror4", alu_res_out, 32'h1000_000F);
    drive(4'b0001, 32'd0, 32'h0000_00F1, 12'h200, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("mov_lsl4", alu_res_out, 32'h0000_0F10);

    drive(4'b0001, 32'd0, 32'd0, 12'h4FF, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk("mov_imm_ror8", alu_res_out, 32'hFF00_0000);
    chk("mov_imm_nzcv", 32'(status_out), 32'h8);

    wb_en_in = 1'b0; dest_in = 4'd5;
    drive(4'b0010, 32'h100, 32'h1111_1111, 12'h004, 1'b0, 1'b0, 1'b0, 1'b1);
    sel_src2 = 2'd1; fwd_mem_val = 32'hDEAD_BEEF;
    step();
    chk("str_addr", alu_res_out, 32'h104);
    chk("str_data", val_Rm_out, 32'hDEAD_BEEF);
    chk("str_ctrl", 32'({wb_en_out, mem_r_en_out, mem_w_en_out}), 32'h1);

    freeze = 1'b1; pc_in = 32'h20; signed_imm_24_in = 24'hFFFFFE;
    for (int i = 0; i < 3; i++) begin
      wb_en_in = 1'b1; dest_in = 4'(i + 8);
      drive(4'b0010, 32'(i + 1), 32'hFFFF_FFFF, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0);
      step();
      chk("frz_alu", alu_res_out, 32'h104);
      chk("frz_status", 32'(status_out), 32'h8);
      chk("frz_data", val_Rm_out, 32'hDEAD_BEEF);
      chk("branch", branch_address, 32'h18);
    end
    freeze = 1'b0;

    drive(4'b0010, 32'hFFFF_FFFF, 32'd1, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("add_carry_res", alu_res_out, 32'd0);
    chk("add_carry_nzcv", 32'(status_out), 32'h6);
    drive(4'b0011, 32'd1, 32'd1, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("adc_res", alu_res_out, 32'd3);
    chk("adc_nzcv", 32'(status_out), 32'h0);

    drive(4'b0110, 32'h1234_5678, 32'hFF00_FF00, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    sel_src1 = 2'd2; fwd_wb_val = 32'h0F0F_0F0F;
    step();
    chk("tst_fwd_wb", alu_res_out, 32'h0F00_0F00);

    drive(4'b1001, 32'd0, 32'd0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("mvn_res", alu_res_out, 32'hFFFF_FFFF);
    chk("mvn_nzcv", 32'(status_out), 32'h8);
    drive(4'b0000, 32'd7, 32'd7, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("undef_res", alu_res_out, 32'd0);
    chk("undef_nzcv", 32'(status_out), 32'h0);

    drive(4'b0100, 32'h8000_0000, 32'd1, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("sub_ovf_res", alu_res_out, 32'h7FFF_FFFF);
    chk("sub_ovf_nzcv", 32'(status_out), 32'h3);
    drive(4'b0100, 32'd0, 32'd1, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("sub_borrow_nzcv", 32'(status_out), 32'h8);

    #1;
    rst = 1'b0;
    #1;
    chk("midrst_alu", alu_res_out, 32'd0);
    chk("midrst_status", 32'(status_out), 32'd0);
    chk("midrst_data", val_Rm_out, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    drive(4'b1000, 32'h0000_00F0, 32'h0000_00FF, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    sel_src1 = 2'd3; sel_src2 = 2'd3; fwd_mem_val = 32'h5555_5555; fwd_wb_val = 32'hAAAA_AAAA;
    step();
    chk("eor_after_rst", alu_res_out, 32'h0000_000F);
    chk("sel3_data", val_Rm_out, 32'h0000_00FF);

    for (int i = 0; i < 30; i++) begin
      freeze = ($urandom_range(0, 3) == 0);
      wb_en_in = 1'($urandom_range(0, 1));
      dest_in = 4'($urandom_range(0, 15));
      pc_in = $urandom; signed_imm_24_in = 24'($urandom);
      drive(4'($urandom_range(0, 15)), $urandom, $urandom, 12'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
      sel_src1 = 2'($urandom_range(0, 3)); sel_src2 = 2'($urandom_range(0, 3));
      fwd_mem_val = $urandom; fwd_wb_val = $urandom;
      step();
    end
    freeze = 1'b0;
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
